// File: rtl/wt_cache_pkg.sv
// Shared write-through dcache definitions: geometry, read-port count,
// read request/response structs and a saturating counter helper.
package wt_cache_pkg;

   localparam int unsigned DCACHE_SET_ASSOC    = 8;
   localparam int unsigned DCACHE_CL_IDX_WIDTH = 8;
   localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
   localparam int unsigned DCACHE_TAG_WIDTH    = 20;
   localparam int unsigned DCACHE_NUM_RD_PORTS = 3;

   typedef struct packed {
      logic                           req;
      logic                           tag_only;
      logic [DCACHE_CL_IDX_WIDTH-1:0] idx;
      logic [DCACHE_OFFSET_WIDTH-1:0] off;
      logic [DCACHE_TAG_WIDTH-1:0]    tag;
   } dcache_rd_req_t;

   typedef struct packed {
      logic ack;
      logic rsp_vld;
   } dcache_rd_rsp_t;

   // +1 that sticks at the all-ones value instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] cnt);
      logic [31:0] res;
      if (cnt == 32'hFFFF_FFFF) begin
         res = cnt;
      end else begin
         res = cnt + 32'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/wt_dcache_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr_i,
// wrapping NumPorts-1 -> 0. Returns one-hot grant and its index.
module wt_dcache_rr_pick #(
   parameter int unsigned NumPorts = 3,
   parameter int unsigned PtrW     = 2
) (
   input  logic [NumPorts-1:0] req_i,
   input  logic [PtrW-1:0]     ptr_i,
   output logic [NumPorts-1:0] gnt_oh_o,
   output logic [PtrW-1:0]     idx_o
);

   // scan NumPorts candidates starting at the pointer, keep the first hit
   always_comb begin
      logic        found;
      int unsigned cand;
      gnt_oh_o = '0;
      idx_o    = '0;
      found    = 1'b0;
      cand     = 0;
      for (int unsigned i = 0; i < NumPorts; i++) begin
         cand = 32'(ptr_i) + i;
         if (cand >= NumPorts) begin
            cand = cand - NumPorts;
         end else begin
            cand = cand;
         end
         for (int unsigned p = 0; p < NumPorts; p++) begin
            if (!found && (p == cand) && req_i[p]) begin
               found       = 1'b1;
               gnt_oh_o[p] = 1'b1;
               idx_o       = PtrW'(p);
            end else begin
               found = found;
            end
         end
      end
   end

endmodule

// File: rtl/wt_dcache_rd_arbiter.sv
// Round-robin arbiter sharing the dcache memory read port among NumPorts
// read controllers. Ack is same-cycle; the tag and the response owner flag
// follow one cycle later, steered by the registered winner index.
// Optional stall counters are built when WT_DCACHE_RD_ARB_PERF_EN is defined.
module wt_dcache_rd_arbiter
   import wt_cache_pkg::*;
#(
   parameter int unsigned NumPorts = DCACHE_NUM_RD_PORTS,
   parameter int unsigned IdxW     = DCACHE_CL_IDX_WIDTH,
   parameter int unsigned OffW     = DCACHE_OFFSET_WIDTH,
   parameter int unsigned TagW     = DCACHE_TAG_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
`ifdef WT_DCACHE_RD_ARB_PERF_EN
   output logic [NumPorts*32-1:0]      stall_cnt_o,
`endif
   input  logic [NumPorts-1:0]         rd_req_i,
   input  logic [NumPorts-1:0]         rd_tag_only_i,
   input  logic [NumPorts*IdxW-1:0]    rd_idx_i,
   input  logic [NumPorts*OffW-1:0]    rd_off_i,
   input  logic [NumPorts*TagW-1:0]    rd_tag_i,
   output logic [NumPorts-1:0]         rd_ack_o,
   output logic [NumPorts-1:0]         rd_rsp_vld_o,
   output logic [63:0]                 rd_data_o,
   output logic [DCACHE_SET_ASSOC-1:0] rd_vld_bits_o,
   output logic [DCACHE_SET_ASSOC-1:0] rd_hit_oh_o,
   output logic                        mem_rd_req_o,
   input  logic                        mem_rd_gnt_i,
   output logic [IdxW-1:0]             mem_rd_idx_o,
   output logic [OffW-1:0]             mem_rd_off_o,
   output logic                        mem_rd_tag_only_o,
   output logic [TagW-1:0]             mem_rd_tag_o,
   input  logic [63:0]                 mem_rd_data_i,
   input  logic [DCACHE_SET_ASSOC-1:0] mem_rd_vld_bits_i,
   input  logic [DCACHE_SET_ASSOC-1:0] mem_rd_hit_oh_i
);

   localparam int unsigned PtrW = $clog2(NumPorts);

   dcache_rd_req_t      req_s [NumPorts];
   dcache_rd_rsp_t      rsp_s [NumPorts];
   logic [NumPorts-1:0] req_vec;
   logic [NumPorts-1:0] win_oh;
   logic [PtrW-1:0]     win_idx;
   logic                gnt_fire;

   logic [PtrW-1:0]     rr_ptr_d, rr_ptr_q;
   logic [PtrW-1:0]     sel_d, sel_q;
   logic                inflight_d, inflight_q;

   // gather the flat per-port buses into request structs
   always_comb begin
      req_vec = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         req_s[p].req      = rd_req_i[p];
         req_s[p].tag_only = rd_tag_only_i[p];
         req_s[p].idx      = DCACHE_CL_IDX_WIDTH'(rd_idx_i[p*IdxW +: IdxW]);
         req_s[p].off      = DCACHE_OFFSET_WIDTH'(rd_off_i[p*OffW +: OffW]);
         req_s[p].tag      = DCACHE_TAG_WIDTH'(rd_tag_i[p*TagW +: TagW]);
         req_vec[p]        = req_s[p].req;
      end
   end

   wt_dcache_rr_pick #(
      .NumPorts (NumPorts),
      .PtrW     (PtrW)
   ) i_rr_pick (
      .req_i    (req_vec),
      .ptr_i    (rr_ptr_q),
      .gnt_oh_o (win_oh),
      .idx_o    (win_idx)
   );

   // memory request side: winner's idx/off/tag_only, previous winner's tag
   always_comb begin
      mem_rd_req_o      = |req_vec;
      gnt_fire          = mem_rd_req_o & mem_rd_gnt_i;
      mem_rd_idx_o      = '0;
      mem_rd_off_o      = '0;
      mem_rd_tag_only_o = 1'b0;
      mem_rd_tag_o      = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         if (win_oh[p]) begin
            mem_rd_idx_o      = IdxW'(req_s[p].idx);
            mem_rd_off_o      = OffW'(req_s[p].off);
            mem_rd_tag_only_o = req_s[p].tag_only;
         end else begin
            mem_rd_tag_only_o = mem_rd_tag_only_o;
         end
         if (inflight_q && (sel_q == PtrW'(p))) begin
            mem_rd_tag_o = TagW'(req_s[p].tag);
         end else begin
            mem_rd_tag_o = mem_rd_tag_o;
         end
      end
   end

   // per-port ack and response-owner flags; read data is broadcast
   always_comb begin
      rd_ack_o     = '0;
      rd_rsp_vld_o = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         rsp_s[p].ack     = win_oh[p] & gnt_fire;
         rsp_s[p].rsp_vld = inflight_q & (sel_q == PtrW'(p));
         rd_ack_o[p]      = rsp_s[p].ack;
         rd_rsp_vld_o[p]  = rsp_s[p].rsp_vld;
      end
      rd_data_o     = mem_rd_data_i;
      rd_vld_bits_o = mem_rd_vld_bits_i;
      rd_hit_oh_o   = mem_rd_hit_oh_i;
   end

   // next state: remember the winner and move the pointer past it on a grant
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      sel_d      = sel_q;
      inflight_d = 1'b0;
      if (gnt_fire) begin
         sel_d      = win_idx;
         inflight_d = 1'b1;
         if (win_idx == PtrW'(NumPorts - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = win_idx + PtrW'(1);
         end
      end else begin
         rr_ptr_d   = rr_ptr_q;
         inflight_d = 1'b0;
      end
   end

   // arbitration state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q   <= '0;
         sel_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         sel_q      <= sel_d;
         inflight_q <= inflight_d;
      end
   end

`ifdef WT_DCACHE_RD_ARB_PERF_EN
   logic [31:0] stall_cnt_d [NumPorts];
   logic [31:0] stall_cnt_q [NumPorts];

   // count cycles a port requests without being acked, saturating
   always_comb begin
      stall_cnt_o = '0;
      for (int unsigned p = 0; p < NumPorts; p++) begin
         if (req_vec[p] && !rsp_s[p].ack) begin
            stall_cnt_d[p] = sat_inc32(stall_cnt_q[p]);
         end else begin
            stall_cnt_d[p] = stall_cnt_q[p];
         end
         stall_cnt_o[p*32 +: 32] = stall_cnt_q[p];
      end
   end

   // stall counter registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned p = 0; p < NumPorts; p++) begin
            stall_cnt_q[p] <= 32'd0;
         end
      end else begin
         for (int unsigned p = 0; p < NumPorts; p++) begin
            stall_cnt_q[p] <= stall_cnt_d[p];
         end
      end
   end
`endif

endmodule
